// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the write-back stage: data width, register
// address width, the buffered write-back entry and a few small helpers.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One pending register-file write. from_lsu marks results that must
  // release a scoreboard bit when they commit.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  from_lsu;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  // Which producer owns the write port in the current cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

  // x0 is architecturally constant, so it never receives a write and is
  // never tracked as pending.
  function automatic logic is_reg_zero(input logic [REG_ADDR_W-1:0] r);
    return (r == REG_ZERO);
  endfunction

  // One-hot mask for a destination register, with x0 always masked out.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] r);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (!is_reg_zero(r)) begin
      m[r] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding LSU write-back entries until the register
// file write port is free. Depth must be a power of two so the pointers wrap
// naturally.
module wb_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [WB_ENTRY_W-1:0]   wdata_i,
  input  logic                    pop_i,
  output logic [WB_ENTRY_W-1:0]   rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // A pop is only honoured when data is present; a push into a full buffer is
  // allowed only when the head leaves in the same cycle.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  // Next-state pointers and occupancy from the effective push/pop pair.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless while empty so it needs no reset.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wb_entry_t'(wdata_i);
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port driver: merges single-cycle ALU results with
// buffered LSU results (ALU first), tracks destinations of outstanding loads
// for decode hazard checks, and requests an ALU bubble when the LSU buffer
// has been starved for too long.
module writeback_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  input  logic            issue_long_i,
  input  logic [4:0]      issue_rd_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      rd_addr_i,
  output logic            hazard_o,
  output logic            stall_o,
  output logic            RegWrite_o,
  output logic [4:0]      register_write_addr_o,
  output logic [XLEN-1:0] register_write_data_o
);

  import rv32i_pkg::*;

  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [COUNT_W-1:0]  FIFO_FULL_COUNT = COUNT_W'(FIFO_DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_LAST     = STARVE_W'(STARVE_LIMIT - 1);

  // FIFO interface
  wb_entry_t          lsuEntry;
  wb_entry_t          fifoHead;
  logic               fifoPush;
  logic               fifoPop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [COUNT_W-1:0] fifoCount;

  // Arbitration result
  wb_src_e            wbSrc;
  wb_entry_t          aluEntry;
  wb_entry_t          selEntry;

  // Output register
  logic               regWrite_q;
  logic [4:0]         wbAddr_q;
  logic [XLEN-1:0]    wbData_q;
  logic               wbFromLsu_q;

  // Scoreboard
  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Starvation tracking
  logic [STARVE_W-1:0] starveCount_q, starveCount_d;
  logic                stall_q, stall_d;

  assign lsuEntry = '{rd: lsu_rd_i, data: lsu_data_i, from_lsu: 1'b1};
  assign aluEntry = '{rd: alu_rd_i, data: alu_data_i, from_lsu: 1'b0};

  // Ready depends only on occupancy (and is held low in reset), never on
  // lsu_valid_i, so the LSU can use it without a combinational loop.
  assign lsu_ready_o = rst_n && (fifoCount != FIFO_FULL_COUNT);
  assign fifoPush    = lsu_valid_i && lsu_ready_o;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_lsu_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifoPush),
    .wdata_i (lsuEntry),
    .pop_i   (fifoPop),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // Pick this cycle's writer: ALU has strict priority, the buffered LSU head
  // only goes out in cycles without ALU traffic.
  always_comb begin
    wbSrc    = SRC_NONE;
    selEntry = '0;
    fifoPop  = 1'b0;
    if (alu_valid_i) begin
      wbSrc    = SRC_ALU;
      selEntry = aluEntry;
    end else if (!fifoEmpty) begin
      wbSrc    = SRC_LSU;
      selEntry = fifoHead;
      fifoPop  = 1'b1;
    end
  end

  // Register the selected write. An x0 destination still updates address and
  // data but keeps the write enable low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regWrite_q  <= 1'b0;
      wbAddr_q    <= '0;
      wbData_q    <= '0;
      wbFromLsu_q <= 1'b0;
    end else if (wbSrc != SRC_NONE) begin
      regWrite_q  <= !is_reg_zero(selEntry.rd);
      wbAddr_q    <= selEntry.rd;
      wbData_q    <= selEntry.data;
      wbFromLsu_q <= selEntry.from_lsu;
    end else begin
      regWrite_q  <= 1'b0;
      wbFromLsu_q <= 1'b0;
    end
  end

  // Pending-destination update: an LSU write clears its bit on the edge the
  // register file commits it, a new load issue sets a bit, and a set on the
  // same register in the same cycle overrides the clear.
  always_comb begin
    pending_d = pending_q;
    if (regWrite_q && wbFromLsu_q) begin
      pending_d = pending_d & ~reg_mask(wbAddr_q);
    end
    if (issue_long_i) begin
      pending_d = pending_d | reg_mask(issue_rd_i);
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign hazard_o = pending_q[rs1_addr_i] | pending_q[rs2_addr_i] | pending_q[rd_addr_i];

  // Count consecutive cycles where the ALU keeps the port while the LSU
  // buffer is full; on the last one request a single bubble and restart.
  always_comb begin
    starveCount_d = '0;
    stall_d       = 1'b0;
    if (fifoFull && alu_valid_i) begin
      if (starveCount_q == STARVE_LAST) begin
        stall_d = 1'b1;
      end else begin
        starveCount_d = starveCount_q + 1'b1;
      end
    end
  end

  // Starvation counter and registered bubble request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starveCount_q <= '0;
      stall_q       <= 1'b0;
    end else begin
      starveCount_q <= starveCount_d;
      stall_q       <= stall_d;
    end
  end

  assign stall_o               = stall_q;
  assign RegWrite_o            = regWrite_q;
  assign register_write_addr_o = wbAddr_q;
  assign register_write_data_o = wbData_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: table-driven ALU and hazard
// vectors, hand-written multi-cycle sequences, and a write scoreboard queue
// that every register-file write is compared against.
module tb_writeback_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        issue_long_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [4:0]  rd_addr_i;
  logic        hazard_o;
  logic        stall_o;
  logic        RegWrite_o;
  logic [4:0]  register_write_addr_o;
  logic [31:0] register_write_data_o;

  int totalChecks = 0;
  int badChecks   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wbExp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        expWe;
  } aluVec_t;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       expHaz;
  } hazVec_t;

  wbExp_t  expQ[$];
  wbExp_t  monExp;
  aluVec_t aluTab[5];
  hazVec_t hazTab[7];
  logic    expReady[12];

  writeback_arbiter dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .alu_valid_i           (alu_valid_i),
    .alu_rd_i              (alu_rd_i),
    .alu_data_i            (alu_data_i),
    .lsu_valid_i           (lsu_valid_i),
    .lsu_ready_o           (lsu_ready_o),
    .lsu_rd_i              (lsu_rd_i),
    .lsu_data_i            (lsu_data_i),
    .issue_long_i          (issue_long_i),
    .issue_rd_i            (issue_rd_i),
    .rs1_addr_i            (rs1_addr_i),
    .rs2_addr_i            (rs2_addr_i),
    .rd_addr_i             (rd_addr_i),
    .hazard_o              (hazard_o),
    .stall_o               (stall_o),
    .RegWrite_o            (RegWrite_o),
    .register_write_addr_o (register_write_addr_o),
    .register_write_data_o (register_write_data_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expectWrite(input logic [4:0] addr, input logic [31:0] data);
    wbExp_t e;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Drive one cycle of stimulus, let one rising edge sample it, and return at
  // the following falling edge where outputs are stable.
  task automatic applyStimulus(input logic aluV, input logic [4:0] aluRd, input logic [31:0] aluData,
                               input logic lsuV, input logic [4:0] lsuRd, input logic [31:0] lsuData,
                               input logic iss, input logic [4:0] issRd);
    alu_valid_i  = aluV;
    alu_rd_i     = aluRd;
    alu_data_i   = aluData;
    lsu_valid_i  = lsuV;
    lsu_rd_i     = lsuRd;
    lsu_data_i   = lsuData;
    issue_long_i = iss;
    issue_rd_i   = issRd;
    if (aluV && aluRd != 5'd0) begin
      expectWrite(aluRd, aluData);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    end
  endtask

  task automatic queryHazard(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input logic exp, input string name);
    rs1_addr_i = r1;
    rs2_addr_i = r2;
    rd_addr_i  = rd;
    #1;
    checkOutput(name, 32'(hazard_o), 32'(exp));
  endtask

  // Every committed write must match the oldest expected write.
  always @(negedge clk) begin
    if (RegWrite_o === 1'b1) begin
      if (expQ.size() == 0) begin
        totalChecks++;
        badChecks++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h expected no write at %0t",
                 register_write_addr_o, register_write_data_o, $time);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("wb_addr", 32'(register_write_addr_o), 32'(monExp.addr));
        checkOutput("wb_data", register_write_data_o, monExp.data);
      end
    end
  end

  // While a bubble is requested the pipeline keeps the ALU idle; an ALU
  // result here means the bubble arrived at the wrong time.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && stall_o === 1'b1) begin
      checkOutput("bubble_alu_idle", 32'(alu_valid_i), 32'd0);
    end
  end

  initial begin
    aluTab[0] = '{5'd5,  32'hDEADBEEF, 1'b1};
    aluTab[1] = '{5'd0,  32'h12345678, 1'b0};
    aluTab[2] = '{5'd31, 32'hFFFFFFFF, 1'b1};
    aluTab[3] = '{5'd1,  32'h00000000, 1'b1};
    aluTab[4] = '{5'd17, 32'hA5A5A5A5, 1'b1};

    hazTab[0] = '{5'd7,  5'd0,  5'd0,  1'b1};
    hazTab[1] = '{5'd0,  5'd20, 5'd0,  1'b1};
    hazTab[2] = '{5'd0,  5'd0,  5'd7,  1'b1};
    hazTab[3] = '{5'd1,  5'd2,  5'd3,  1'b0};
    hazTab[4] = '{5'd0,  5'd0,  5'd0,  1'b0};
    hazTab[5] = '{5'd6,  5'd8,  5'd21, 1'b0};
    hazTab[6] = '{5'd20, 5'd7,  5'd0,  1'b1};

    expReady = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n        = 1'b0;
    alu_valid_i  = 1'b0;
    alu_rd_i     = '0;
    alu_data_i   = '0;
    lsu_valid_i  = 1'b0;
    lsu_rd_i     = '0;
    lsu_data_i   = '0;
    issue_long_i = 1'b0;
    issue_rd_i   = '0;
    rs1_addr_i   = 5'd5;
    rs2_addr_i   = '0;
    rd_addr_i    = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_regwrite", 32'(RegWrite_o), 32'd0);
    checkOutput("rst_addr", 32'(register_write_addr_o), 32'd0);
    checkOutput("rst_data", register_write_data_o, 32'd0);
    checkOutput("rst_stall", 32'(stall_o), 32'd0);
    checkOutput("rst_ready_low", 32'(lsu_ready_o), 32'd0);
    checkOutput("rst_hazard", 32'(hazard_o), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_rst", 32'(lsu_ready_o), 32'd1);

    // ALU vectors back to back: one write per cycle, x0 suppressed
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, aluTab[i].rd, aluTab[i].data, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      checkOutput("alu_we", 32'(RegWrite_o), 32'(aluTab[i].expWe));
      checkOutput("alu_addr", 32'(register_write_addr_o), 32'(aluTab[i].rd));
      if (!aluTab[i].expWe) begin
        checkOutput("alu_x0_data", register_write_data_o, aluTab[i].data);
      end
    end
    idleCycles(1);
    checkOutput("idle_no_write", 32'(RegWrite_o), 32'd0);

    // Load hazard: issue loads to x7, x20 and x0, then query
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    for (int i = 0; i < 7; i++) begin
      queryHazard(hazTab[i].rs1, hazTab[i].rs2, hazTab[i].rd, hazTab[i].expHaz, "hazard_table");
    end

    // x7 returns: still pending after N and N+1, clear after N+2
    queryHazard(5'd7, 5'd0, 5'd0, 1'b1, "haz7_before");
    expectWrite(5'd7, 32'h00001234);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h00001234, 1'b0, 5'd0);
    queryHazard(5'd7, 5'd0, 5'd0, 1'b1, "haz7_after_n");
    idleCycles(1);
    queryHazard(5'd7, 5'd0, 5'd0, 1'b1, "haz7_after_n1");
    checkOutput("lsu7_we", 32'(RegWrite_o), 32'd1);
    idleCycles(1);
    queryHazard(5'd7, 5'd0, 5'd0, 1'b0, "haz7_after_n2");
    queryHazard(5'd0, 5'd20, 5'd0, 1'b1, "haz20_still");
    expectWrite(5'd20, 32'h00002020);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h00002020, 1'b0, 5'd0);
    idleCycles(2);
    queryHazard(5'd0, 5'd20, 5'd0, 1'b0, "haz20_cleared");

    // x0 LSU result: popped, address/data driven, no write
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
    idleCycles(1);
    checkOutput("x0_we", 32'(RegWrite_o), 32'd0);
    checkOutput("x0_addr", 32'(register_write_addr_o), 32'd0);
    checkOutput("x0_data", register_write_data_o, 32'hFFFFFFFF);
    idleCycles(1);
    checkOutput("x0_ready", 32'(lsu_ready_o), 32'd1);
    queryHazard(5'd0, 5'd0, 5'd0, 1'b0, "x0_haz");

    // Set wins over a same-edge commit on x9
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    expectWrite(5'd9, 32'h00000099);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0);
    idleCycles(1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    queryHazard(5'd0, 5'd9, 5'd0, 1'b1, "set_wins_haz9");
    expectWrite(5'd9, 32'h00000098);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h00000098, 1'b0, 5'd0);
    idleCycles(2);
    queryHazard(5'd0, 5'd9, 5'd0, 1'b0, "haz9_cleared");

    // Priority and buffering: ALU burst with a bubble, three LSU offers
    issue_long_i = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      alu_valid_i = (k <= 6) || (k == 8) || (k == 9);
      alu_rd_i    = alu_valid_i ? 5'(k) : 5'd0;
      alu_data_i  = 32'hA000 + 32'(k);
      if (alu_valid_i) begin
        expectWrite(5'(k), 32'hA000 + 32'(k));
      end
      if (k == 7) begin
        expectWrite(5'd10, 32'hB00A);
      end
      if (k == 9) begin
        expectWrite(5'd11, 32'hB00B);
        expectWrite(5'd12, 32'hB00C);
      end
      lsu_valid_i = (k <= 8);
      lsu_rd_i    = (k == 1) ? 5'd10 : (k == 2) ? 5'd11 : 5'd12;
      lsu_data_i  = (k == 1) ? 32'hB00A : (k == 2) ? 32'hB00B : 32'hB00C;
      #1;
      checkOutput("burst_ready", 32'(lsu_ready_o), 32'(expReady[k]));
      @(posedge clk);
      @(negedge clk);
      checkOutput("burst_stall", 32'(stall_o), (k == 6) ? 32'd1 : 32'd0);
    end
    idleCycles(1);

    // Reset mid-burst discards two buffered loads and their pending bits
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd14);
    applyStimulus(1'b1, 5'd1, 32'h00001111, 1'b1, 5'd13, 32'h00000D13, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd2, 32'h00002222, 1'b1, 5'd14, 32'h00000D14, 1'b0, 5'd0);
    checkOutput("pre_rst_full", 32'(lsu_ready_o), 32'd0);
    alu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_we", 32'(RegWrite_o), 32'd0);
    checkOutput("midrst_ready", 32'(lsu_ready_o), 32'd1);
    checkOutput("midrst_stall", 32'(stall_o), 32'd0);
    queryHazard(5'd13, 5'd14, 5'd0, 1'b0, "midrst_haz");
    for (int i = 0; i < 3; i++) begin
      idleCycles(1);
      checkOutput("midrst_no_write", 32'(RegWrite_o), 32'd0);
    end

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

- Write-side driver for the RV32I register file.
- Merges two result producers into the single register-file write port:
  - single-cycle ALU results;
  - variable-latency load/store-unit (LSU) results, delivered over a valid/ready handshake.
- Keeps a pending-destination scoreboard so decode can stall on RAW/WAW hazards against outstanding loads.
- Sits between execute/memory and the register file. Its outputs connect directly to the file's write address, write data and write enable.

## Interface
Parameters:
- XLEN, 32, data width.
- FIFO_DEPTH, 2, LSU result buffer entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive full-FIFO cycles before `stall_o` is raised.

Ports:
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst_n`  in  1  reset, synchronous active-low (fixed).
- `alu_valid_i`  in  1  ALU result present this cycle. No backpressure; always consumed.
- `alu_rd_i`  in  5  ALU destination register.
- `alu_data_i`  in  XLEN  ALU result.
- `lsu_valid_i`  in  1  LSU result offered.
- `lsu_ready_o`  out  1  Buffer can accept; equals !full. Low while `rst_n`=0.
- `lsu_rd_i`  in  5  LSU destination register.
- `lsu_data_i`  in  XLEN  LSU result.
- `issue_long_i`  in  1  Decode issued a load; marks `issue_rd_i` pending.
- `issue_rd_i`  in  5  destination of the issued load.
- `rs1_addr_i`, `rs2_addr_i`, `rd_addr_i`  in  5 each  operands of the instruction in decode.
- `hazard_o`  out  1  Combinational: any of the three addresses is pending (x0 never pending).
- `stall_o`  out  1  Registered: requests a one-cycle ALU bubble.
- `RegWrite_o`  out  1  Register-file write enable (registered).
- `register_write_addr_o`  out  5  write address (registered).
- `register_write_data_o`  out  XLEN  write data (registered).

## Operation
- **Reset** (`rst_n`=0 at an edge): FIFO emptied, scoreboard cleared, starvation counter 0.
  - `RegWrite_o`=0, address=0, data=0, `stall_o`=0.
  - Reset mid-operation discards buffered LSU results without writing them.
- **LSU accept:** push when `lsu_valid_i` and `lsu_ready_o` are both high at an edge. Push and pop in the same cycle are allowed when the FIFO is full.
- **Arbitration per cycle:**
  - `alu_valid_i` high: the ALU result is registered to the outputs.
  - Otherwise, if the FIFO is non-empty: pop the head and register it.
  - Otherwise: `RegWrite_o`=0.
  - The ALU has strict priority.
- **x0:** a selected entry with rd=0 still drives address and data, but `RegWrite_o`=0. It is still popped.
- **Scoreboard (32 bits, bit 0 hardwired 0):**
  - Set at the edge where `issue_long_i`=1 and `issue_rd_i`≠0.
  - Cleared at the edge where `RegWrite_o`=1 and the write came from the LSU path for that rd. This is the edge the register file commits.
  - Same-edge set and clear on the same rd: set wins.
  - Decode must not issue while `hazard_o`=1. Because `rd_addr_i` is included in the check, there is never more than one outstanding load per rd.
- **Starvation:**
  - Counter increments each cycle the FIFO is full and `alu_valid_i`=1; otherwise it resets to 0.
  - On reaching STARVE_LIMIT: `stall_o`=1 for exactly one cycle and the counter resets.
  - Pipeline contract: `alu_valid_i`=0 in the cycle after `stall_o`=1.
- **Assertion:** `alu_valid_i`=1 in the cycle following `stall_o`=1 is a protocol error (bench assertion).

## Timing
- **ALU path:** sampled at edge N → `RegWrite_o` high in cycle N..N+1 → register file updated at edge N+1.
- **LSU path, FIFO empty, no ALU traffic:**
  - accepted at edge N, popped at edge N+1, committed at edge N+2;
  - scoreboard bit clears at edge N+2;
  - `hazard_o` drops in the cycle after N+2, when the register-file read already returns the new value.
- **Throughput:** one register-file write per cycle.
- **Buffer:** sustains FIFO_DEPTH back-to-back LSU results during an ALU burst before `lsu_ready_o` drops.
- **`lsu_ready_o`:** combinational from the FIFO count only; it does not depend on `lsu_valid_i`.

## Structure
- Shared package `rv32i_pkg`:
  - `XLEN`;
  - `REG_ADDR_W`=5;
  - `wb_entry_t` {rd[4:0], data[XLEN-1:0], from_lsu};
  - constant `REG_ZERO`=5'd0.
- One sub-module, `wb_fifo`: a parameterised synchronous FIFO of `wb_entry_t` with push/pop/full/empty/count.
- Arbitration, output register, scoreboard and starvation counter live in the top module.

## Test plan
- **Reset mid-burst:** 2 LSU results buffered, `rst_n`=0 for one edge → no writes; `lsu_ready_o`=1, `hazard_o`=0, `RegWrite_o`=0 afterwards.
- **ALU single write:** `alu_valid_i`=1, rd=5, data=0xDEADBEEF at edge N → cycle after N shows `RegWrite_o`=1, addr=5, data=0xDEADBEEF.
- **Load hazard:** issue load rd=7; query `rs1_addr_i`=7 → `hazard_o`=1. LSU returns 0x1234 at edge N → `hazard_o`=0 from the cycle after N+2, and x7 reads 0x1234.
- **Priority and buffering:** ALU valid every cycle for 8 cycles, plus 3 LSU offers.
  - First 2 accepted, then `lsu_ready_o`=0.
  - `stall_o` pulses after 4 full cycles.
  - The LSU head is written in the bubble.
- **x0 discard:** LSU result rd=0, data=0xFFFFFFFF → popped, `RegWrite_o`=0, scoreboard unchanged.
- **Set-wins:** issue load rd=9 on the same edge as an LSU commit to rd=9 → bit 9 remains set and `hazard_o`=1 for rd 9.
